// File: rtl/hilo_pkg.sv
// Shared types and defaults for the HI/LO register unit.
package hilo_pkg;

  localparam int HILO_WIDTH       = 32;
  localparam int HILO_MAX_LATENCY = 64;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } hilo_state_t;

  // Counter width able to hold 0..max_latency inclusive.
  function automatic int pend_cnt_width(input int max_latency);
    return (max_latency < 2) ? 1 : $clog2(max_latency + 1);
  endfunction

endpackage

// File: rtl/hilo_pending_ctr.sv
// Saturating count of cycles an operation has been pending, with a sticky
// timeout flag raised on the edge the count reaches MAX_LATENCY.
module hilo_pending_ctr
  import hilo_pkg::*;
#(
  parameter int MAX_LATENCY = HILO_MAX_LATENCY
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic err_timeout
);

  localparam int CW = pend_cnt_width(MAX_LATENCY);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_LATENCY);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LATENCY - 1);

  logic [CW-1:0] pend_cnt_reg;
  logic          err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else if (clear) begin
      pend_cnt_reg <= '0;
    end else if (enable && (pend_cnt_reg != CNT_MAX)) begin
      pend_cnt_reg <= pend_cnt_reg + 1'b1;
      // Sticky: only reset can clear it.
      if (pend_cnt_reg == CNT_LAST) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err_timeout = err_reg;

endmodule

// File: rtl/hilo_unit.sv
// Architectural HI/LO register pair fed by the MULT/DIV unit, with stall logic.
// Define HILO_BYPASS_EN to forward a completing result straight to MFHI/MFLO.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH       = HILO_WIDTH,
  parameter int MAX_LATENCY = HILO_MAX_LATENCY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_in,
  input  logic             result_valid,
  input  logic [WIDTH-1:0] result_hi,
  input  logic [WIDTH-1:0] result_lo,
  input  logic             mthi_en,
  input  logic             mtlo_en,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             mf_req,
  input  logic             mf_sel_hi,
  output logic [WIDTH-1:0] mf_data,
  output logic             stall,
  output logic             busy,
  output logic             err_timeout
);

  hilo_state_t      state_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic any_req;
  logic bypass_hit;
  logic pending;
  logic capture;
  logic accept_start;

  assign pending = (state_reg == PENDING);
  assign capture = pending & result_valid;
  assign any_req = mf_req | mthi_en | mtlo_en | start_in;

`ifdef HILO_BYPASS_EN
  // Only a lone read may ride on the completing result.
  assign bypass_hit = capture & mf_req & ~mthi_en & ~mtlo_en & ~start_in;
`else
  assign bypass_hit = 1'b0;
`endif

  assign stall        = pending & any_req & ~bypass_hit;
  assign busy         = pending;
  assign accept_start = ~pending & start_in;

  always_comb begin
    mf_data = '0;
    if (mf_req) begin
      if (bypass_hit) begin
        mf_data = mf_sel_hi ? result_hi : result_lo;
      end else begin
        mf_data = mf_sel_hi ? hi_reg : lo_reg;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      // A stalled MT never lands; a completing result always wins.
      if (capture) begin
        hi_reg <= result_hi;
        lo_reg <= result_lo;
      end else if (!stall) begin
        if (mthi_en) hi_reg <= mt_data;
        if (mtlo_en) lo_reg <= mt_data;
      end

      case (state_reg)
        IDLE:    if (start_in) state_reg <= PENDING;
        PENDING: if (result_valid) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  hilo_pending_ctr #(
    .MAX_LATENCY(MAX_LATENCY)
  ) u_pending_ctr (
    .clk        (clk),
    .reset      (reset),
    .clear      (accept_start),
    .enable     (pending),
    .err_timeout(err_timeout)
  );

endmodule
